// File: rtl/char_fill_engine.sv
// rtl/char_fill_engine.sv - character buffer fill engine (CLS/SEQ/ROW/RECT plus status row repaint)
module char_fill_engine #(
    parameter int COL_W       = 7,
    parameter int ROW_W       = 5,
    parameter int COLS        = 80,
    parameter int DATA_W      = 7,
    parameter int STATUS_CHAR = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [ROW_W-1:0]       cmd_row0,
    input  logic [ROW_W-1:0]       cmd_row1,
    input  logic [COL_W-1:0]       cmd_col0,
    input  logic [COL_W-1:0]       cmd_col1,
    input  logic [DATA_W-1:0]      cmd_char,
    input  logic [ROW_W-1:0]       scroll_row,
    input  logic                   status_req,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic [COL_W+ROW_W-1:0] wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   cmd_err,
    output logic                   stat_done
);
    localparam int                ROWS      = 2**ROW_W;
    localparam logic [COL_W:0]    COLS_X    = (COL_W+1)'(COLS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS-1);
    localparam logic [DATA_W-1:0] STAT_CODE = DATA_W'(STATUS_CHAR);
    localparam logic [2:0] OP_CLS = 3'd0, OP_SEQ = 3'd1, OP_ROW = 3'd2, OP_RECT = 3'd3;

    typedef enum logic [1:0] {IDLE, RUN, STAT} state_t;
    state_t state, state_nxt;

    logic              stat_pend;
    logic [COL_W-1:0]  col, col_start, col_end;
    logic [ROW_W-1:0]  row, row_end, scroll;
    logic [DATA_W-1:0] data;
    logic              seq_inc;
    logic              accept, cmd_ok, beat, last;

    assign cmd_ready = (state == IDLE) & ~stat_pend;
    assign accept    = cmd_valid & cmd_ready;
    assign wr_en     = (state != IDLE);
    assign busy      = (state != IDLE);
    assign beat      = wr_en & wr_ready;
    assign last      = (col == col_end) & (row == row_end);
    // Logical row plus scroll wraps naturally in ROW_W bits.
    assign wr_addr   = {col, row + scroll};
    assign wr_data   = data;

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_op)
            OP_CLS, OP_SEQ: cmd_ok = 1'b1;
            OP_ROW:         cmd_ok = ({1'b0, cmd_col0} < COLS_X);
            OP_RECT:        cmd_ok = ({1'b0, cmd_col0} < COLS_X) & ({1'b0, cmd_col1} < COLS_X) &
                                     (cmd_col0 <= cmd_col1) & (cmd_row0 <= cmd_row1);
            default:        cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (stat_pend)
                    state_nxt = STAT;
                else if (accept && cmd_ok)
                    state_nxt = RUN;
            end
            RUN, STAT: begin
                if (beat && last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pend <= 1'b0;
            col       <= '0;
            col_start <= '0;
            col_end   <= '0;
            row       <= '0;
            row_end   <= '0;
            scroll    <= '0;
            data      <= '0;
            seq_inc   <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            stat_done <= 1'b0;
        end else begin
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            stat_done <= 1'b0;
            // Entering STAT happens exactly when IDLE sees a pending request.
            stat_pend <= status_req | (stat_pend & (state != IDLE));
            if (state == IDLE) begin
                if (stat_pend) begin
                    col       <= '0;
                    col_start <= '0;
                    col_end   <= COL_LAST;
                    row       <= ROW_LAST;
                    row_end   <= ROW_LAST;
                    scroll    <= scroll_row;
                    data      <= STAT_CODE;
                    seq_inc   <= 1'b0;
                end else if (accept) begin
                    if (cmd_ok) begin
                        scroll  <= scroll_row;
                        data    <= cmd_char;
                        seq_inc <= (cmd_op == OP_SEQ);
                        case (cmd_op)
                            OP_CLS, OP_SEQ: begin
                                col       <= '0;
                                col_start <= '0;
                                col_end   <= COL_LAST;
                                row       <= '0;
                                row_end   <= ROW_LAST;
                            end
                            OP_ROW: begin
                                col       <= cmd_col0;
                                col_start <= cmd_col0;
                                col_end   <= COL_LAST;
                                row       <= cmd_row0;
                                row_end   <= cmd_row0;
                            end
                            default: begin
                                col       <= cmd_col0;
                                col_start <= cmd_col0;
                                col_end   <= cmd_col1;
                                row       <= cmd_row0;
                                row_end   <= cmd_row1;
                            end
                        endcase
                    end else begin
                        done    <= 1'b1;
                        cmd_err <= 1'b1;
                    end
                end
            end else if (beat) begin
                data <= data + {{(DATA_W-1){1'b0}}, seq_inc};
                if (last) begin
                    done      <= (state == RUN);
                    stat_done <= (state == STAT);
                end else if (col == col_end) begin
                    col <= col_start;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_char_fill_engine.sv
// tb/tb_char_fill_engine.sv - scoreboard bench for char_fill_engine with directed vectors
module tb_char_fill_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_row0 = '0, cmd_row1 = '0;
    logic [6:0]  cmd_col0 = '0, cmd_col1 = '0;
    logic [6:0]  cmd_char = '0;
    logic [4:0]  scroll_row = '0;
    logic        status_req = 1'b0;
    logic        wr_en;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic        busy, done, cmd_err, stat_done;

    char_fill_engine dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_row0(cmd_row0), .cmd_row1(cmd_row1),
        .cmd_col0(cmd_col0), .cmd_col1(cmd_col1), .cmd_char(cmd_char),
        .scroll_row(scroll_row), .status_req(status_req), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .cmd_err(cmd_err), .stat_done(stat_done)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [18:0] beat_q[$];
    logic [2:0]  ev_q[$];
    logic [18:0] beat_log[$];
    int rdy_mode = 0;
    int alt_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // wr_ready: constant high, or alternating with 1 in cycles alt_base+1, +3, ...
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wr_ready = (rdy_mode == 0) ? 1'b1 : 1'((cyc - alt_base) & 1);
        end
    end

    // Monitor: pops expected beats and completion flags, and checks stall stability.
    initial begin
        logic        st_prev;
        logic [18:0] prev, exp_b;
        logic [2:0]  exp_e;
        st_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                st_prev = 1'b0;
            end else begin
                if (st_prev && wr_en)
                    check("stall_hold", {wr_addr, wr_data}, prev);
                st_prev = wr_en & ~wr_ready;
                prev = {wr_addr, wr_data};
                if (wr_en && wr_ready) begin
                    beat_log.push_back({wr_addr, wr_data});
                    if (beat_q.size() == 0)
                        check("beat_q_nonempty", 32'(beat_q.size()), 1);
                    else begin
                        exp_b = beat_q.pop_front();
                        check($sformatf("beat%0d_addr_data", beat_log.size()), {wr_addr, wr_data}, exp_b);
                    end
                end
                if (done || stat_done || cmd_err) begin
                    if (ev_q.size() == 0)
                        check("ev_q_nonempty", 32'(ev_q.size()), 1);
                    else begin
                        exp_e = ev_q.pop_front();
                        check("done_err_stat", {done, cmd_err, stat_done}, exp_e);
                    end
                end
            end
        end
    end

    task automatic exp_region(input int r0, input int r1, input int c0, input int c1,
                              input int sc, input logic [6:0] ch, input bit seq);
        logic [6:0] d;
        d = ch;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++) begin
                beat_q.push_back({12'(c * 32 + ((r + sc) % 32)), d});
                if (seq) d = d + 7'd1;
            end
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] ch,
                         output int t);
        @(posedge clk);
        #1;
        cmd_op = op; cmd_row0 = r0; cmd_row1 = r1;
        cmd_col0 = c0; cmd_col1 = c1; cmd_char = ch;
        cmd_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        check("cmd_ready_at_issue", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_evt(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done || stat_done) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t, at, base, d_at, s_at, early;
        bit sent;
        logic [18:0] b;
        logic [2:0]  rj_op[3] = '{3'd3, 3'd5, 3'd2};
        logic [6:0]  rj_c0[3] = '{7'd5, 7'd0, 7'd80};
        logic [6:0]  rj_c1[3] = '{7'd4, 7'd0, 7'd0};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err_stat", {done, cmd_err, stat_done}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset mid-CLS at beat 100: immediate abort, no done
        exp_region(0, 31, 0, 79, 0, 7'h20, 0);
        base = beat_log.size();
        issue(3'd0, 0, 0, 0, 0, 7'h20, t);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (beat_log.size() - base >= 100) break;
        end
        #2 reset = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        beat_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_done", done, 0);

        // CLS 0x20: 2560 beats, done at T+2561
        exp_region(0, 31, 0, 79, 0, 7'h20, 0);
        ev_q.push_back(3'b100);
        base = beat_log.size();
        issue(3'd0, 0, 0, 0, 0, 7'h20, t);
        wait_evt(3000, at);
        check("cls_done_latency", at - t, 2561);
        check("cls_beats", beat_log.size() - base, 2560);
        b = beat_log[base];        check("cls_first_addr", b[18:7], 12'h000);
        b = beat_log[base + 1];    check("cls_second_addr", b[18:7], 12'h020);
        b = beat_log[base + 2559]; check("cls_last_addr", b[18:7], 12'h9FF);

        // SEQ starting 0x7E wraps modulo 128
        exp_region(0, 31, 0, 79, 0, 7'h7E, 1);
        ev_q.push_back(3'b100);
        base = beat_log.size();
        issue(3'd1, 0, 0, 0, 0, 7'h7E, t);
        wait_evt(3000, at);
        check("seq_done_latency", at - t, 2561);
        b = beat_log[base];        check("seq_data0", b[6:0], 7'h7E);
        b = beat_log[base + 1];    check("seq_data1", b[6:0], 7'h7F);
        b = beat_log[base + 2];    check("seq_data2", b[6:0], 7'h00);
        b = beat_log[base + 3];    check("seq_data3", b[6:0], 7'h01);
        b = beat_log[base + 2559]; check("seq_data2559", b[6:0], 7'h7D);

        // ROW 3 from col 75, scroll 30, alternating wr_ready
        scroll_row = 5'd30;
        beat_q.push_back({12'h961, 7'h2A});
        beat_q.push_back({12'h981, 7'h2A});
        beat_q.push_back({12'h9A1, 7'h2A});
        beat_q.push_back({12'h9C1, 7'h2A});
        beat_q.push_back({12'h9E1, 7'h2A});
        ev_q.push_back(3'b100);
        base = beat_log.size();
        alt_base = cyc + 1;
        rdy_mode = 1;
        issue(3'd2, 3, 0, 75, 0, 7'h2A, t);
        wait_evt(40, at);
        rdy_mode = 0;
        check("row_done_latency", at - t, 10);
        check("row_beats", beat_log.size() - base, 5);

        // RECT rows 30..31 cols 2..3, scroll 4
        scroll_row = 5'd4;
        beat_q.push_back({12'h042, 7'h41});
        beat_q.push_back({12'h062, 7'h41});
        beat_q.push_back({12'h043, 7'h41});
        beat_q.push_back({12'h063, 7'h41});
        ev_q.push_back(3'b100);
        base = beat_log.size();
        issue(3'd3, 30, 31, 2, 3, 7'h41, t);
        wait_evt(20, at);
        check("rect_done_latency", at - t, 5);
        check("rect_beats", beat_log.size() - base, 4);

        // Rejected: RECT col0>col1, illegal opcode, ROW col0=80
        for (int k = 0; k < 3; k++) begin
            ev_q.push_back(3'b110);
            base = beat_log.size();
            issue(rj_op[k], 0, 0, rj_c0[k], rj_c1[k], 7'h41, t);
            wait_evt(5, at);
            check($sformatf("rej%0d_latency", k), at - t, 1);
            check($sformatf("rej%0d_cmd_err", k), cmd_err, 1);
            check($sformatf("rej%0d_cmd_ready", k), cmd_ready, 1);
            @(negedge clk);
            check($sformatf("rej%0d_no_beats", k), beat_log.size() - base, 0);
            check($sformatf("rej%0d_idle", k), busy, 0);
        end

        // Status request during CLS with a held command waiting
        scroll_row = 5'd0;
        exp_region(0, 31, 0, 79, 0, 7'h2E, 0);
        for (int c = 0; c < 80; c++) beat_q.push_back({12'(c * 32 + 31), 7'h7F});
        beat_q.push_back({12'h000, 7'h55});
        beat_q.push_back({12'h020, 7'h55});
        ev_q.push_back(3'b100);
        ev_q.push_back(3'b001);
        ev_q.push_back(3'b100);
        base = beat_log.size();
        issue(3'd0, 0, 0, 0, 0, 7'h2E, t);
        cmd_op = 3'd3; cmd_row0 = 0; cmd_row1 = 0;
        cmd_col0 = 0; cmd_col1 = 1; cmd_char = 7'h55;
        cmd_valid = 1'b1;
        d_at = -1; s_at = -1; early = 0; sent = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!sent && beat_log.size() - base >= 10) begin
                status_req = 1'b1;
                sent = 1;
            end else
                status_req = 1'b0;
            if (done && d_at < 0) begin
                d_at = cyc;
                check("cls_done_cmd_ready", cmd_ready, 0);
            end
            if (stat_done) begin
                s_at = cyc;
                check("stat_done_cmd_ready", cmd_ready, 1);
                break;
            end
            if (cmd_ready) early++;
        end
        status_req = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("stat_cls_done_latency", d_at - t, 2561);
        check("stat_done_latency", s_at - d_at, 81);
        check("held_cmd_not_ready_early", early, 0);
        wait_evt(10, at);
        check("held_cmd_done_latency", at - s_at, 3);

        repeat (3) @(negedge clk);
        check("beat_q_drained", beat_q.size(), 0);
        check("ev_q_drained", ev_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
